// File: rtl/bram_port_ctrl.sv
// Request/response front end for one port of a byte-writable block RAM with a
// registered output (2-cycle read latency). Reads are tracked through a 2-stage
// valid pipeline and their data lands in a small response FIFO. A read is only
// accepted while pipeline plus FIFO occupancy leaves a free FIFO slot, so the
// FIFO can never overflow. Writes are fire-and-forget.
module bram_port_ctrl #(
    parameter int unsigned NB_COL        = 4,
    parameter int unsigned COL_WIDTH     = 8,
    parameter int unsigned RAM_ADDR_BITS = 10,
    parameter int unsigned RESP_DEPTH    = 4,
    localparam int unsigned WORD_WIDTH   = NB_COL * COL_WIDTH,
    localparam int unsigned CNT_W        = $clog2(RESP_DEPTH) + 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    // Request channel
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [NB_COL-1:0]        req_we_i,
    input  logic [RAM_ADDR_BITS-1:0] req_addr_i,
    input  logic [WORD_WIDTH-1:0]    req_wdata_i,
    // Response channel
    output logic                     resp_valid_o,
    input  logic                     resp_ready_i,
    output logic [WORD_WIDTH-1:0]    resp_rdata_o,
    // RAM port A
    output logic                     ram_en_o,
    output logic [NB_COL-1:0]        ram_we_o,
    output logic [RAM_ADDR_BITS-1:0] ram_addr_o,
    output logic [WORD_WIDTH-1:0]    ram_wdata_o,
    output logic                     ram_en_reg_o,
    output logic                     ram_rst_o,
    input  logic [WORD_WIDTH-1:0]    ram_rdata_i,
    // Status
    output logic [CNT_W-1:0]         outstanding_o
);

    localparam int unsigned PTR_W = $clog2(RESP_DEPTH);

    // Read tracking pipeline: s1 = RAM array read done, s2 = output register loaded
    logic s1_q;
    logic s2_q;

    // Response FIFO
    logic [WORD_WIDTH-1:0] fifo_mem [RESP_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      count_q;

    logic is_write;
    logic read_credit;
    logic accept;
    logic rd_accept;
    logic push;
    logic pop;
    logic [CNT_W-1:0] outstanding;

    // Credit accounting and request handshake
    always_comb begin
        is_write    = |req_we_i;
        // Pops in the current cycle give no credit: keeps the ready path short.
        outstanding = '0;
        if (!rst_i) begin
            outstanding = CNT_W'(s1_q) + CNT_W'(s2_q) + count_q;
        end
        read_credit = outstanding < CNT_W'(RESP_DEPTH);
        req_ready_o = !rst_i && (is_write || read_credit);
        accept      = req_valid_i && req_ready_o;
        rd_accept   = accept && !is_write;
        outstanding_o = outstanding;
    end

    // RAM port drive: enable only in the accept cycle
    always_comb begin
        ram_en_o     = accept;
        ram_we_o     = accept ? req_we_i : '0;
        ram_addr_o   = req_addr_i;
        ram_wdata_o  = req_wdata_i;
        ram_en_reg_o = !rst_i && s1_q;
        ram_rst_o    = rst_i;
    end

    // Response side: FIFO head is presented directly
    always_comb begin
        resp_valid_o = !rst_i && (count_q != '0);
        resp_rdata_o = fifo_mem[rd_ptr_q];
        push         = !rst_i && s2_q;
        pop          = resp_valid_o && resp_ready_i;
    end

    // Read valid pipeline; reset drops reads in flight
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= rd_accept;
            s2_q <= s1_q;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-two depth
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage: capture RAM output register contents when s2 is set
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= ram_rdata_i;
        end
    end

endmodule

// File: tb/tb_bram_port_ctrl.sv
// Scoreboard bench for bram_port_ctrl. A behavioural RAM (registered output)
// sits on the RAM port. The stimulus task predicts acceptance from the number
// of reads still owed, updates a reference memory and pushes expected read data
// with its accept cycle; a monitor derives valid/outstanding from those cycles
// (response due 3 cycles after accept, in order) and pops on handshake.
module tb_bram_port_ctrl;

    localparam int unsigned NB_COL        = 4;
    localparam int unsigned COL_WIDTH     = 8;
    localparam int unsigned RAM_ADDR_BITS = 10;
    localparam int unsigned RESP_DEPTH    = 4;
    localparam int unsigned W             = NB_COL * COL_WIDTH;
    localparam int unsigned CNT_W         = $clog2(RESP_DEPTH) + 1;

    logic                     clk_i = 1'b0;
    logic                     rst_i = 1'b1;
    logic                     req_valid_i = 1'b0;
    logic                     req_ready_o;
    logic [NB_COL-1:0]        req_we_i = '0;
    logic [RAM_ADDR_BITS-1:0] req_addr_i = '0;
    logic [W-1:0]             req_wdata_i = '0;
    logic                     resp_valid_o;
    logic                     resp_ready_i = 1'b0;
    logic [W-1:0]             resp_rdata_o;
    logic                     ram_en_o;
    logic [NB_COL-1:0]        ram_we_o;
    logic [RAM_ADDR_BITS-1:0] ram_addr_o;
    logic [W-1:0]             ram_wdata_o;
    logic                     ram_en_reg_o;
    logic                     ram_rst_o;
    logic [W-1:0]             ram_rdata_i;
    logic [CNT_W-1:0]         outstanding_o;

    bram_port_ctrl #(
        .NB_COL        (NB_COL),
        .COL_WIDTH     (COL_WIDTH),
        .RAM_ADDR_BITS (RAM_ADDR_BITS),
        .RESP_DEPTH    (RESP_DEPTH)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_we_i      (req_we_i),
        .req_addr_i    (req_addr_i),
        .req_wdata_i   (req_wdata_i),
        .resp_valid_o  (resp_valid_o),
        .resp_ready_i  (resp_ready_i),
        .resp_rdata_o  (resp_rdata_o),
        .ram_en_o      (ram_en_o),
        .ram_we_o      (ram_we_o),
        .ram_addr_o    (ram_addr_o),
        .ram_wdata_o   (ram_wdata_o),
        .ram_en_reg_o  (ram_en_reg_o),
        .ram_rst_o     (ram_rst_o),
        .ram_rdata_i   (ram_rdata_i),
        .outstanding_o (outstanding_o)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural block RAM: read-first array read, then output register
    logic [W-1:0] ram_mem [1 << RAM_ADDR_BITS];
    logic [W-1:0] ram_latch;
    logic [W-1:0] ram_out;

    always @(posedge clk_i) begin
        if (ram_en_o) begin
            ram_latch <= ram_mem[ram_addr_o];
            for (int c = 0; c < int'(NB_COL); c++) begin
                if (ram_we_o[c]) begin
                    ram_mem[ram_addr_o][c*COL_WIDTH +: COL_WIDTH] <=
                        ram_wdata_o[c*COL_WIDTH +: COL_WIDTH];
                end
            end
        end
        if (ram_rst_o) begin
            ram_out <= '0;
        end else if (ram_en_reg_o) begin
            ram_out <= ram_latch;
        end
    end

    assign ram_rdata_i = ram_out;

    // Cycle index, stable between rising edges
    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] data;
        int           acc_cyc;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] ref_mem [16];
    int           checks = 0;
    int           errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One cycle of stimulus; returns whether the DUT accepted the request
    task automatic issue(input bit v, input logic [NB_COL-1:0] we, input logic [3:0] a,
                         input logic [W-1:0] d, input bit rr, input bit rst,
                         output bit dut_acc);
        bit exp_rdy;
        bit exp_acc;
        @(posedge clk_i);
        #1;
        req_valid_i  = v;
        req_we_i     = we;
        req_addr_i   = RAM_ADDR_BITS'(a);
        req_wdata_i  = d;
        resp_ready_i = rr;
        rst_i        = rst;
        @(negedge clk_i);
        exp_rdy = !rst && (we != '0 || sb.size() < int'(RESP_DEPTH));
        exp_acc = v && exp_rdy;
        check("req_ready", 64'(req_ready_o), 64'(exp_rdy));
        check("ram_en", 64'(ram_en_o), 64'(exp_acc));
        check("ram_we", 64'(ram_we_o), 64'(exp_acc ? we : 4'h0));
        if (exp_acc) begin
            check("ram_addr", 64'(ram_addr_o), 64'(a));
        end
        dut_acc = v && req_ready_o;
        if (rst) begin
            sb.delete();
        end else if (exp_acc) begin
            if (we == '0) begin
                sb.push_back('{data: ref_mem[a], acc_cyc: cyc});
            end else begin
                for (int c = 0; c < int'(NB_COL); c++) begin
                    if (we[c]) ref_mem[a][c*COL_WIDTH +: COL_WIDTH] = d[c*COL_WIDTH +: COL_WIDTH];
                end
            end
        end
    endtask

    task automatic idle(input bit rr, input int n);
        bit a;
        for (int i = 0; i < n; i++) issue(1'b0, '0, '0, '0, rr, 1'b0, a);
    endtask

    // Let every owed response retire; a stuck response counts as a failure
    task automatic drain();
        bit a;
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            issue(1'b0, '0, '0, '0, 1'b1, 1'b0, a);
            n++;
        end
        idle(1'b1, 1);
        check("drain_timeout", 64'(sb.size()), 64'(0));
    endtask

    // Monitor: compares DUT response side against expected-response timing
    initial begin
        forever begin
            int  exp_out;
            bit  exp_v;
            bit  exp_en_reg;
            @(negedge clk_i);
            #1;
            exp_out    = 0;
            exp_en_reg = 1'b0;
            foreach (sb[i]) begin
                if (sb[i].acc_cyc < cyc) exp_out++;
                if (sb[i].acc_cyc == cyc - 1) exp_en_reg = 1'b1;
            end
            exp_v = sb.size() > 0 && (sb[0].acc_cyc + 3 <= cyc);
            check("outstanding", 64'(outstanding_o), 64'(exp_out));
            check("resp_valid", 64'(resp_valid_o), 64'(exp_v));
            check("ram_en_reg", 64'(ram_en_reg_o), 64'(exp_en_reg));
            check("ram_rst", 64'(ram_rst_o), 64'(rst_i));
            if (exp_v) begin
                check("resp_rdata", 64'(resp_rdata_o), 64'(sb[0].data));
                if (resp_ready_i) void'(sb.pop_front());
            end
        end
    end

    initial begin
        bit a;
        int n_acc;
        // Reset held for a few cycles
        for (int i = 0; i < 3; i++) issue(1'b0, '0, '0, '0, 1'b1, 1'b1, a);
        // Populate the working address range
        for (int i = 0; i < 16; i++) issue(1'b1, 4'hF, 4'(i), $urandom, 1'b1, 1'b0, a);

        // Write then read addr 5: response due three cycles after accept
        issue(1'b1, 4'hF, 4'd5, 32'hA5A5_A5A5, 1'b1, 1'b0, a);
        issue(1'b1, 4'h0, 4'd5, '0, 1'b1, 1'b0, a);
        drain();

        // Full write then single-column write, then read back merged word
        issue(1'b1, 4'hF, 4'd7, 32'h1122_3344, 1'b1, 1'b0, a);
        issue(1'b1, 4'b0010, 4'd7, 32'hFFFF_FFFF, 1'b1, 1'b0, a);
        issue(1'b1, 4'h0, 4'd7, '0, 1'b1, 1'b0, a);
        drain();

        // Back-pressure: six reads, only RESP_DEPTH accepted; writes still go through
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            issue(1'b1, 4'h0, 4'(i + 2), '0, 1'b0, 1'b0, a);
            n_acc += int'(a);
        end
        check("full_accept_count", 64'(n_acc), 64'(RESP_DEPTH));
        issue(1'b1, 4'hF, 4'd3, 32'hCAFE_0003, 1'b0, 1'b0, a);
        check("write_when_full", 64'(a), 64'(1));
        idle(1'b0, 3);
        drain();

        // Streaming reads at full throughput; FIFO pointers wrap many times
        n_acc = 0;
        for (int i = 0; i < 24; i++) begin
            issue(1'b1, 4'h0, 4'(i), '0, 1'b1, 1'b0, a);
            n_acc += int'(a);
        end
        check("stream_accept_count", 64'(n_acc), 64'(24));
        drain();

        // Reset pulse with two reads in flight: both are dropped
        issue(1'b1, 4'h0, 4'd1, '0, 1'b1, 1'b0, a);
        issue(1'b1, 4'h0, 4'd2, '0, 1'b1, 1'b0, a);
        issue(1'b0, '0, '0, '0, 1'b1, 1'b1, a);
        idle(1'b1, 6);

        // Randomized mix of reads, masked writes and consumer stalls
        for (int i = 0; i < 400; i++) begin
            logic [NB_COL-1:0] we;
            we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            issue(1'($urandom_range(0, 3) != 0), we, 4'($urandom), $urandom,
                  1'($urandom_range(0, 9) < 7), 1'b0, a);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_port_ctrl.md
BRAM_PORT_CTRL -- requirements
Module: bram_port_ctrl

Interface
REQ-001 SHALL have parameter NB_COL, default 4: byte-write columns per word.
REQ-002 SHALL have parameter COL_WIDTH, default 8: bits per column.
REQ-003 SHALL have parameter RAM_ADDR_BITS, default 10: word address width.
REQ-004 SHALL have parameter RESP_DEPTH, default 4 (power of two, >=2): response FIFO entries.
REQ-005 SHALL derive WORD_WIDTH = NB_COL*COL_WIDTH.
REQ-006 SHALL use one clock and a synchronous, active-high reset, with all state updated on the rising edge of clk_i.
REQ-007 SHALL have port clk_i, input, 1: clock.
REQ-008 SHALL have port rst_i, input, 1: synchronous active-high reset.
REQ-009 SHALL have port req_valid_i, input, 1: request valid.
REQ-010 SHALL have port req_ready_o, output, 1: request accepted when valid&ready.
REQ-011 SHALL have port req_we_i, input, NB_COL: byte-write mask; all-zero means read.
REQ-012 SHALL have port req_addr_i, input, RAM_ADDR_BITS: word address.
REQ-013 SHALL have port req_wdata_i, input, WORD_WIDTH: write data.
REQ-014 SHALL have port resp_valid_o, output, 1: read data valid.
REQ-015 SHALL have port resp_ready_i, input, 1: consumer accepts read data.
REQ-016 SHALL have port resp_rdata_o, output, WORD_WIDTH: read data.
REQ-017 SHALL have port ram_en_o, output, 1: to RAM port-A enable.
REQ-018 SHALL have port ram_we_o, output, NB_COL: to RAM port-A byte-write enables.
REQ-019 SHALL have port ram_addr_o, output, RAM_ADDR_BITS: to RAM port-A address.
REQ-020 SHALL have port ram_wdata_o, output, WORD_WIDTH: to RAM port-A write data.
REQ-021 SHALL have port ram_en_reg_o, output, 1: to RAM output-register enable.
REQ-022 SHALL have port ram_rst_o, output, 1: to RAM output-register reset.
REQ-023 SHALL have port ram_rdata_i, input, WORD_WIDTH: from RAM registered port-A output (2-cycle latency).
REQ-024 SHALL have port outstanding_o, output, clog2(RESP_DEPTH)+1: reads in pipeline plus FIFO.

Function
REQ-025 SHALL drive ram_en_o=1, ram_we_o=req_we_i, ram_addr_o=req_addr_i, ram_wdata_o=req_wdata_i combinationally in the accept cycle T, and otherwise drive ram_en_o=0 and ram_we_o=0.
REQ-026 SHALL track reads in a 2-stage valid pipeline: s1 set at T+1, s2 set at T+2.
REQ-027 SHALL assert ram_en_reg_o = s1, so the RAM output register captures read data at the end of T+1.
REQ-028 SHALL push ram_rdata_i into the response FIFO at the end of cycle T+2 when s2=1.
REQ-029 SHALL give a read with resp_ready_i=1 and an empty FIFO resp_valid_o=1 at T+3 (latency 3).
REQ-030 SHALL accept writes (req_we_i!=0) whenever not in reset, and writes SHALL produce no response.
REQ-031 SHALL accept reads only when outstanding_o < RESP_DEPTH, with no credit for a same-cycle pop, so that the FIFO never overflows.
REQ-032 SHALL set req_ready_o = !rst_i & (req_we_i!=0 | outstanding_o<RESP_DEPTH).
REQ-033 SHALL compute outstanding_o = s1 + s2 + fifo_count; a read accept SHALL increment it and a pop (resp_valid_o&resp_ready_i) SHALL decrement it, with both in one cycle leaving it unchanged.
REQ-034 SHALL implement the FIFO with wrapping read/write pointers, supporting simultaneous push and pop when non-empty and returning responses in request order.
REQ-035 SHALL drive resp_valid_o = FIFO not empty and resp_rdata_o = FIFO head, holding both stable while resp_valid_o=1 and resp_ready_i=0.
REQ-036 SHALL give read-first semantics for a write followed by a read of the same address: the read issued at T+1 returns the new data.
REQ-037 SHALL drive ram_rst_o = rst_i.

Reset
REQ-038 SHALL, while rst_i=1, clear s1, s2, FIFO pointers and count, and hold req_ready_o=0, resp_valid_o=0, ram_en_o=0, ram_we_o=0, ram_en_reg_o=0 and outstanding_o=0.
REQ-039 SHALL discard reads in flight when rst_i is asserted mid-operation, so that no response appears after reset releases.

Verification
REQ-040 Bench SHALL cover: write addr 5 data 0xA5A5A5A5 mask 4'hF, then read addr 5 -> resp_valid_o at T+3 with 0xA5A5A5A5.
REQ-041 Bench SHALL cover: write addr 7 with 0x11223344, then write 0xFFFFFFFF mask 4'b0010, then read -> 0x1122FF44.
REQ-042 Bench SHALL cover: resp_ready_i=0 with 6 back-to-back reads -> exactly 4 accepted, req_ready_o=0 for reads with outstanding_o=4, writes still accepted; release -> 4 responses in order.
REQ-043 Bench SHALL cover: continuous reads with resp_ready_i=1 -> one response per cycle, throughput 1, pointer wrap-around exercised.
REQ-044 Bench SHALL cover: rst_i pulsed 1 cycle with 2 reads in flight -> outstanding_o=0, no resp_valid_o afterwards.
